// File: rtl/bram_req_master.sv
// Burst initiator for the single-port BRAM request/done protocol.
// Accepts one read or write burst command, issues one word request at a time
// (one outstanding request), streams write data in and read data out, and
// reports completion with an error flag when the controller fails to answer.
//
// Ports:
//   clk, reset                     clock (posedge), asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_addr, cmd_len   burst direction, start address, word count (0 = no-op)
//   cmd_done, cmd_err              one-cycle completion pulse, error (timeout) flag
//   wr_data/wr_valid/wr_ready      write word stream
//   rd_data/rd_valid               registered read word and its one-cycle strobe
//   mem_req, mem_access            request strobe and direction (1 = write) to controller
//   mem_addr_in, mem_data_in       request address and write data
//   mem_data_out, mem_done         read data and acknowledge from controller
module bram_req_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE       = 1000,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  cmd_done,
    output logic                  cmd_err,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  mem_req,
    output logic                  mem_access,
    output logic [ADDR_WIDTH-1:0] mem_addr_in,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_done
);

    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   write_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    logic                   timer_expired;
    logic                   last_word;

    assign timer_expired = (timer_q == TIMER_WIDTH'(TIMEOUT - 1));
    assign last_word     = (remaining_q == LEN_WIDTH'(1));

    // Direction and address are held in registers so they stay stable all burst.
    assign mem_access  = write_q;
    assign mem_addr_in = addr_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // A write with no data available stalls here; no timeout accrues.
                if (!write_q || wr_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    state_next = last_word ? DONE : ISSUE;
                end else if (timer_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic; mem_req is decoded from state so reset drops it at once.
    always_comb begin
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        mem_req     = 1'b0;
        mem_data_in = wdata_q;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            ISSUE: begin
                if (write_q) begin
                    wr_ready    = 1'b1;
                    mem_req     = wr_valid;
                    mem_data_in = wr_data;
                end else begin
                    mem_req = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Burst bookkeeping, timeout timer and registered status/read outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            wdata_q     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cmd_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        remaining_q <= cmd_len;
                        cmd_err     <= 1'b0;
                        timer_q     <= '0;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    if (write_q && wr_valid) begin
                        wdata_q <= wr_data;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        timer_q     <= '0;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        addr_q      <= (addr_q == ADDR_WIDTH'(SIZE - 1)) ? '0
                                                                         : addr_q + ADDR_WIDTH'(1);
                        if (!write_q) begin
                            rd_data  <= mem_data_out;
                            rd_valid <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        // Abort: remaining words are dropped.
                        timer_q <= '0;
                        cmd_err <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_req_master.sv
// Directed testbench for bram_req_master paired with a small BRAM controller
// model (acknowledge one cycle after mem_req, optional stuck-silent mode).
module tb_bram_req_master;

    localparam int unsigned DW = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned SZ = 11;
    localparam int unsigned LW = 8;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_done, cmd_err;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mem_req, mem_access;
    logic [AW-1:0] mem_addr_in;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_done;

    always #5 clk = ~clk;

    bram_req_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .LEN_WIDTH(LW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_req(mem_req), .mem_access(mem_access), .mem_addr_in(mem_addr_in),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_done(mem_done)
    );

    // Controller model
    logic [DW-1:0] mem [0:15];
    logic          ctl_done;
    logic [DW-1:0] ctl_q;
    logic          stub, spur;

    assign mem_done     = (ctl_done & ~stub) | spur;
    assign mem_data_out = ctl_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_done <= 1'b0;
            ctl_q    <= '0;
        end else begin
            ctl_done <= mem_req;
            if (mem_req) begin
                if (mem_access) mem[mem_addr_in] <= mem_data_in;
                else            ctl_q <= mem[mem_addr_in];
            end
        end
    end

    // Cycle counter and event log
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int req_n = 0, rd_n = 0, done_n = 0;
    int req_cyc [64], req_addr [64], req_acc [64], req_dat [64];
    int rd_cyc [64], rd_dat [64];
    int done_cyc [64], done_err [64];

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && req_n < 64) begin
                req_cyc[req_n]  = cyc;
                req_addr[req_n] = int'(mem_addr_in);
                req_acc[req_n]  = int'(mem_access);
                req_dat[req_n]  = int'(mem_data_in);
                req_n++;
            end
            if (rd_valid && rd_n < 64) begin
                rd_cyc[rd_n] = cyc;
                rd_dat[rd_n] = int'(rd_data);
                rd_n++;
            end
            if (cmd_done && done_n < 64) begin
                done_cyc[done_n] = cyc;
                done_err[done_n] = int'(cmd_err);
                done_n++;
            end
        end
    end

    int n_tests = 0, n_fail = 0;
    int r0, d0, c0, acc;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Write stream source
    logic [DW-1:0] wr_q [4];
    int wr_n = 0, wr_idx = 0, gap_at = 0, gap_len = 0, gap_cnt = 0;

    task automatic drive_wr();
        wr_valid = (wr_idx < wr_n) && (gap_cnt == 0);
        wr_data  = (wr_idx < 4) ? wr_q[wr_idx] : '0;
    endtask

    task automatic set_wr(input int n, input int a, input int b, input int c, input int d,
                          input int g_at, input int g_len);
        wr_q[0] = DW'(a); wr_q[1] = DW'(b); wr_q[2] = DW'(c); wr_q[3] = DW'(d);
        wr_n = n; wr_idx = 0; gap_at = g_at; gap_len = g_len; gap_cnt = 0;
        drive_wr();
    endtask

    task automatic tick();
        logic consumed;
        consumed = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        if (gap_cnt > 0) gap_cnt--;
        if (consumed) begin
            wr_idx++;
            if (wr_idx == gap_at) gap_cnt = gap_len;
        end
        drive_wr();
    endtask

    task automatic mark();
        r0 = req_n; d0 = rd_n; c0 = done_n;
    endtask

    task automatic send_cmd(input logic w, input int a, input int l);
        check("cmd_ready_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(a); cmd_len = LW'(l);
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_n == c0 && k < budget) begin
            tick();
            k++;
        end
        tick();
        tick();
        check("done_count", done_n - c0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        stub = 1'b0; spur = 1'b0;
        set_wr(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_cmd_done", int'(cmd_done), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_mem_addr", int'(mem_addr_in), 0);
        check("rst_mem_access", int'(mem_access), 0);
        check("rst_mem_data_in", int'(mem_data_in), 0);
        reset = 1'b0;
        tick();

        // Write addr 2, len 3, data 5,6,7
        mark();
        set_wr(3, 5, 6, 7, 0, 0, 0);
        send_cmd(1'b1, 2, 3);
        wait_done(40);
        check("w1_req_count", req_n - r0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w1_addr%0d", i), req_addr[r0+i], 2 + i);
            check($sformatf("w1_acc%0d", i), req_acc[r0+i], 1);
            check($sformatf("w1_data%0d", i), req_dat[r0+i], 5 + i);
        end
        check("w1_first_req", req_cyc[r0], acc + 1);
        check("w1_spacing1", req_cyc[r0+1] - req_cyc[r0], 2);
        check("w1_spacing2", req_cyc[r0+2] - req_cyc[r0+1], 2);
        check("w1_done_cyc", done_cyc[c0], req_cyc[r0+2] + 3);
        check("w1_err", done_err[c0], 0);
        check("w1_no_rd", rd_n - d0, 0);

        // Read addr 2, len 3 -> 5,6,7
        mark();
        send_cmd(1'b0, 2, 3);
        wait_done(40);
        check("r1_rd_count", rd_n - d0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("r1_data%0d", i), rd_dat[d0+i], 5 + i);
            check($sformatf("r1_acc%0d", i), req_acc[r0+i], 0);
        end
        check("r1_latency", rd_cyc[d0], req_cyc[r0] + 2);
        check("r1_spacing", rd_cyc[d0+1] - rd_cyc[d0], 2);
        check("r1_err", done_err[c0], 0);

        // Wrapping write addr 9, len 4, then read back
        mark();
        set_wr(4, 1, 2, 3, 4, 0, 0);
        send_cmd(1'b1, 9, 4);
        wait_done(40);
        check("w2_req_count", req_n - r0, 4);
        check("w2_addr0", req_addr[r0], 9);
        check("w2_addr1", req_addr[r0+1], 10);
        check("w2_addr2", req_addr[r0+2], 0);
        check("w2_addr3", req_addr[r0+3], 1);
        mark();
        send_cmd(1'b0, 9, 4);
        wait_done(40);
        check("r2_rd_count", rd_n - d0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("r2_data%0d", i), rd_dat[d0+i], 1 + i);
        end

        // Write stall: wr_valid low for 3 cycles after word 0
        mark();
        set_wr(2, 3, 4, 0, 0, 1, 3);
        send_cmd(1'b1, 5, 2);
        wait_done(40);
        check("w3_req_count", req_n - r0, 2);
        check("w3_stall_gap", req_cyc[r0+1] - req_cyc[r0], 4);
        check("w3_err", done_err[c0], 0);
        mark();
        send_cmd(1'b0, 5, 2);
        wait_done(40);
        check("r3_data0", rd_dat[d0], 3);
        check("r3_data1", rd_dat[d0+1], 4);

        // Silent controller: timeout after TIMEOUT cycles in WAIT
        stub = 1'b1;
        mark();
        send_cmd(1'b0, 0, 2);
        wait_done(60);
        check("to_req_count", req_n - r0, 1);
        check("to_err", done_err[c0], 1);
        check("to_done_cyc", done_cyc[c0], req_cyc[r0] + 1 + int'(TO) + 1);
        check("to_no_rd", rd_n - d0, 0);
        check("to_err_held", int'(cmd_err), 1);
        stub = 1'b0;

        // Zero-length command; also clears the held error
        mark();
        send_cmd(1'b1, 3, 0);
        check("z_err_cleared", int'(cmd_err), 0);
        wait_done(20);
        check("z_done_cyc", done_cyc[c0], acc + 2);
        check("z_no_req", req_n - r0, 0);
        check("z_err", done_err[c0], 0);

        // mem_done while idle is ignored
        mark();
        spur = 1'b1;
        tick(); tick();
        spur = 1'b0;
        tick(); tick(); tick();
        check("sp_no_rd", rd_n - d0, 0);
        check("sp_no_done", done_n - c0, 0);
        check("sp_no_req", req_n - r0, 0);

        // Reset mid-burst
        mark();
        send_cmd(1'b0, 2, 3);
        check("mr_req_before", int'(mem_req), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_req_dropped", int'(mem_req), 0);
        check("mr_cmd_ready", int'(cmd_ready), 1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("mr_no_done", done_n - c0, 0);
        mark();
        send_cmd(1'b0, 2, 3);
        wait_done(40);
        check("mr_rd_count", rd_n - d0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mr_data%0d", i), rd_dat[d0+i], 5 + i);
        end
        check("mr_err", done_err[c0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
